// File: rtl/nic_ctrl_pkg.sv
// nic_ctrl_pkg: shared state encoding, NIC register map and status bit position
package nic_ctrl_pkg;
    typedef enum logic [1:0] {POLL_RX, READ_RX, POLL_TX, WRITE_TX} state_t;
    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;
    localparam int NIC_STAT_BIT = 63;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: free-running event counter that wraps modulo 2^CNT_WIDTH
// clk, reset (sync, active-high) | i_inc: count this cycle | o_count: current value
module wrap_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);
    always_ff @(posedge clk)
        o_count <= reset ? '0 : o_count + {{(CNT_WIDTH-1){1'b0}}, i_inc};
endmodule

// File: rtl/nic_access_ctrl.sv
// nic_access_ctrl: round-robin RX/TX sequencer between the PE core and the NIC register port
// clk, reset (sync, active-high)
// tx_valid/tx_data/tx_ready: upstream packets to write into the NIC output buffer
// rx_valid/rx_data/rx_ready: one-entry slot holding packets drained from the NIC input
// nic_addr/nic_en/nic_en_wr/nic_d_in/nic_d_out: NIC register access, one per cycle
// tx_count/rx_count: wrapping counts of packets written and read
module nic_access_ctrl import nic_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [0:DATA_WIDTH-1] tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [0:DATA_WIDTH-1] rx_data,
    input  logic                  rx_ready,
    output logic [0:1]            nic_addr,
    output logic                  nic_en,
    output logic                  nic_en_wr,
    output logic [0:DATA_WIDTH-1] nic_d_in,
    input  logic [0:DATA_WIDTH-1] nic_d_out,
    output logic [CNT_WIDTH-1:0]  tx_count,
    output logic [CNT_WIDTH-1:0]  rx_count
);
    state_t r_state, w_next;
    logic   w_rx_load;
    logic   w_stat;
    always_ff @(posedge clk)
        r_state <= reset ? POLL_RX : w_next;
    // Outputs are decoded from state; reset masks every NIC side effect in the current cycle
    always_comb begin
        w_stat    = nic_d_out[NIC_STAT_BIT];
        w_next    = r_state == POLL_RX ? ((w_stat && (!rx_valid || rx_ready)) ? READ_RX : POLL_TX) :
                    r_state == READ_RX ? POLL_TX :
                    r_state == POLL_TX ? ((!w_stat && tx_valid) ? WRITE_TX : POLL_RX) :
                    POLL_RX;
        nic_en    = !reset;
        nic_en_wr = !reset && r_state == WRITE_TX;
        tx_ready  = nic_en_wr;
        w_rx_load = !reset && r_state == READ_RX;
        nic_addr  = reset ? NIC_IN_DATA :
                    r_state == POLL_RX ? NIC_IN_STAT :
                    r_state == READ_RX ? NIC_IN_DATA :
                    r_state == POLL_TX ? NIC_OUT_STAT : NIC_OUT_DATA;
        nic_d_in  = tx_data;
    end
    // A load always wins over a consume: READ_RX is only reached when the slot is free
    always_ff @(posedge clk)
        if (reset) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (w_rx_load) begin
            rx_valid <= 1'b1;
            rx_data  <= nic_d_out;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    wrap_counter #(.CNT_WIDTH(CNT_WIDTH)) u_tx_cnt (
        .clk(clk), .reset(reset), .i_inc(tx_ready), .o_count(tx_count)
    );
    wrap_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rx_cnt (
        .clk(clk), .reset(reset), .i_inc(w_rx_load), .o_count(rx_count)
    );
endmodule

// File: tb/tb_nic_access_ctrl.sv
// tb_nic_access_ctrl: directed bench with a behavioural NIC and a per-cycle scoreboard
module tb_nic_access_ctrl;
    localparam int DW = 64;
    localparam int CW = 16;
    logic clk = 1'b0, reset = 1'b1, tx_valid = 1'b0, rx_ready = 1'b0, out_full = 1'b0;
    logic [0:DW-1] tx_data = '0, rx_data, nic_d_in, nic_d_out;
    logic tx_ready, rx_valid, nic_en, nic_en_wr;
    logic [0:1] nic_addr;
    logic [CW-1:0] tx_count, rx_count;
    logic [0:DW-1] in_mem [256];
    logic [7:0] in_head = 8'd0, in_tail = 8'd0;
    int errors = 0, checks = 0, cyc = 0;
    logic [0:DW-1] exp_rx[$], exp_tx[$];
    int wr_cyc[$];
    logic [CW-1:0] m_rx_cnt, m_tx_cnt;
    logic m_valid;
    logic [0:DW-1] m_data;
    logic p_rst = 1'b1, p_stat = 1'b0, p_free = 1'b0, p_txv = 1'b0;
    logic [1:0] p_addr = 2'b00, e_addr;

    nic_access_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .nic_addr(nic_addr),
        .nic_en(nic_en), .nic_en_wr(nic_en_wr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural NIC: input FIFO behind registers 00/01, output full flag behind 11
    assign nic_d_out = nic_addr == 2'b00 ? in_mem[in_head] :
                       nic_addr == 2'b01 ? {63'b0, in_head != in_tail} :
                       nic_addr == 2'b11 ? {63'b0, out_full} : '0;
    always @(posedge clk) if (nic_en && nic_addr == 2'b00) in_head <= in_head + 8'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
    endtask

    function automatic logic [0:DW-1] pkt(input int k);
        logic [0:DW-1] d;
        d = 64'(k) << 8;
        d[0] = k[0];
        return d;
    endfunction

    task automatic push_rx(input logic [0:DW-1] p);
        in_mem[in_tail] = p;
        in_tail = in_tail + 8'd1;
        exp_rx.push_back(p);
    endtask

    task automatic tx_send(input logic [0:DW-1] p);
        int n;
        tx_valid = 1'b1;
        tx_data = p;
        exp_tx.push_back(p);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 200);
        if (!tx_ready) fail("tx_timeout");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Scoreboard: slot contents, counters, delivery order and the NIC access sequence
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_nic_en", nic_en, 0);
            chk("rst_nic_en_wr", nic_en_wr, 0);
            chk("rst_tx_ready", tx_ready, 0);
            chk("rst_nic_addr", nic_addr, 0);
            m_valid = 1'b0;
            m_data = '0;
            m_rx_cnt = '0;
            m_tx_cnt = '0;
            p_rst = 1'b1;
        end else begin
            chk("rx_valid", rx_valid, m_valid);
            if (m_valid) chk("rx_data", rx_data, m_data);
            chk("rx_count", rx_count, m_rx_cnt);
            chk("tx_count", tx_count, m_tx_cnt);
            chk("nic_en", nic_en, 1);
            chk("tx_ready_is_wr", tx_ready, nic_en_wr);
            chk("wr_at_out_data", nic_en_wr, nic_addr == 2'b10);
            e_addr = p_rst ? 2'b01 :
                     p_addr == 2'b01 ? ((p_stat && p_free) ? 2'b00 : 2'b11) :
                     p_addr == 2'b00 ? 2'b11 :
                     p_addr == 2'b11 ? ((!p_stat && p_txv) ? 2'b10 : 2'b01) : 2'b01;
            chk("addr_seq", nic_addr, e_addr);
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) fail("rx_unexpected");
                else chk("rx_order", rx_data, exp_rx.pop_front());
            end
            if (nic_en_wr) begin
                if (exp_tx.size() == 0) fail("tx_unexpected");
                else chk("tx_write_data", nic_d_in, exp_tx.pop_front());
                m_tx_cnt = m_tx_cnt + 1'b1;
                wr_cyc.push_back(cyc);
            end
            if (nic_addr == 2'b00) begin
                chk("pop_slot_free", rx_valid, 0);
                m_valid = 1'b1;
                m_data = nic_d_out;
                m_rx_cnt = m_rx_cnt + 1'b1;
            end else if (m_valid && rx_ready) begin
                m_valid = 1'b0;
            end
            p_rst = 1'b0;
            p_addr = nic_addr;
            p_stat = nic_d_out[63];
            p_free = !rx_valid || rx_ready;
            p_txv = tx_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rx_count", rx_count, 0);
        chk("reset_tx_count", tx_count, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);

        // RX packets one at a time, downstream always ready
        rx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            push_rx(pkt(k));
            t0 = cyc;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rx_valid && n < 20);
            if (!rx_valid) fail("t1_rx_timeout");
            else begin
                chk("t1_rx_value", rx_data, pkt(k));
                chk("t1_latency_le5", (cyc - t0) <= 5, 1);
            end
        end
        repeat (4) @(negedge clk);
        chk("t1_rx_count", rx_count, 10);
        chk("t1_all_consumed", exp_rx.size(), 0);

        // TX stream with alternating VC bits, output never full
        wr_cyc.delete();
        for (int k = 0; k < 10; k++) tx_send(pkt(k));
        repeat (3) @(negedge clk);
        chk("t2_tx_count", tx_count, 10);
        chk("t2_writes", wr_cyc.size(), 10);
        for (int i = 1; i < wr_cyc.size(); i++) chk("t2_write_gap", wr_cyc[i] - wr_cyc[i-1], 3);

        // Output buffer full for 20 cycles
        @(posedge clk);
        #1;
        out_full = 1'b1;
        fork
            tx_send(pkt(50));
            begin
                repeat (20) @(negedge clk);
                chk("t3_no_write_when_full", tx_count, 10);
                @(posedge clk);
                #1;
                out_full = 1'b0;
                t0 = cyc;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!tx_ready && n < 10);
                if (!tx_ready) fail("t3_write_after_clear");
                else chk("t3_write_delay_le4", (cyc - t0) <= 4, 1);
            end
        join
        repeat (2) @(negedge clk);
        chk("t3_tx_count", tx_count, 11);

        // Slot backpressure: second packet must stay inside the NIC
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        push_rx(pkt(100));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_valid && n < 20);
        if (!rx_valid) fail("t4_first_timeout");
        @(posedge clk);
        #1;
        push_rx(pkt(101));
        repeat (15) @(negedge clk);
        chk("t4_rx_count_held", rx_count, 11);
        chk("t4_slot_holds_first", rx_data, pkt(100));
        chk("t4_nic_still_full", in_head != in_tail, 1);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        t0 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rx_valid && rx_data == pkt(101)) && n < 20);
        if (!(rx_valid && rx_data == pkt(101))) fail("t4_second_timeout");
        else chk("t4_delay_2_to_4", (cyc - t0) >= 2 && (cyc - t0) <= 4, 1);
        repeat (2) @(negedge clk);
        chk("t4_rx_count", rx_count, 12);

        // Concurrent streams of 100 packets each way
        @(posedge clk);
        #1;
        t0 = cyc;
        fork
            for (int k = 0; k < 100; k++) push_rx(pkt(200 + k));
            for (int k = 0; k < 100; k++) tx_send(pkt(400 + k));
        join
        n = 0;
        while (rx_count != 16'd112 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_duration_le410", (cyc - t0) <= 410, 1);
        repeat (2) @(negedge clk);
        chk("t5_rx_count", rx_count, 112);
        chk("t5_tx_count", tx_count, 111);
        chk("t5_rx_drained", exp_rx.size(), 0);

        // Reset landing on a WRITE_TX cycle
        fork
            tx_send(pkt(999));
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!nic_en_wr && n < 20);
                if (!nic_en_wr) fail("t6_no_write_state");
                reset = 1'b1;
                #1;
                chk("t6_wr_masked", nic_en_wr, 0);
                chk("t6_ready_masked", tx_ready, 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                chk("t6_tx_count_cleared", tx_count, 0);
                chk("t6_rx_count_cleared", rx_count, 0);
            end
        join
        repeat (2) @(negedge clk);
        chk("t6_tx_count_after", tx_count, 1);
        chk("t6_packet_written", exp_tx.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
